// File: rtl/ifu_axi_ar_slice.sv
// Registered AXI AR slice: 2-entry skid buffer between the IFU fetch-miss path and the bus,
// with an outstanding-read cap and a sticky completion-underflow flag.
module ifu_axi_ar_slice #(
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 3,
  parameter int MAX_OUT = 4,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  output logic              ifu_axi_arvalid,
  input  logic              ifu_axi_arready,
  output logic [ADDR_W-1:0] ifu_axi_araddr,
  output logic [ID_W-1:0]   ifu_axi_arid,
  input  logic              rsp_done,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_underflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] main_addr_reg;
  logic [ID_W-1:0]   main_id_reg;
  logic [ADDR_W-1:0] skid_addr_reg;
  logic [ID_W-1:0]   skid_id_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              err_reg;
  logic              s_fire;
  logic              m_fire;
  logic              done_valid;

  // Both handshake qualifiers are decoded purely from state/counter registers.
  assign ifu_axi_arvalid = (state_reg != ST_EMPTY);
  assign req_ready       = (state_reg != ST_FULL) && (cnt_reg < MAX_CNT);
  assign ifu_axi_araddr  = main_addr_reg;
  assign ifu_axi_arid    = main_id_reg;
  assign outstanding     = cnt_reg;
  assign err_underflow   = err_reg;

  assign s_fire     = req_valid & req_ready;
  assign m_fire     = ifu_axi_arvalid & ifu_axi_arready;
  assign done_valid = rsp_done && (cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      main_addr_reg <= '0;
      main_id_reg   <= '0;
      skid_addr_reg <= '0;
      skid_id_reg   <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (s_fire) begin
            main_addr_reg <= req_addr;
            main_id_reg   <= req_id;
            state_reg     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (s_fire && m_fire) begin
            main_addr_reg <= req_addr;
            main_id_reg   <= req_id;
          end else if (s_fire) begin
            skid_addr_reg <= req_addr;
            skid_id_reg   <= req_id;
            state_reg     <= ST_FULL;
          end else if (m_fire) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (m_fire) begin
            main_addr_reg <= skid_addr_reg;
            main_id_reg   <= skid_id_reg;
            state_reg     <= ST_ONE;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  // A completion with nothing in flight is not counted; it only raises the sticky flag.
  always_comb begin
    cnt_next = cnt_reg;
    if (s_fire && !done_valid) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (!s_fire && done_valid) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (rsp_done && (cnt_reg == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_axi_ar_slice.sv
// Scenario bench for ifu_axi_ar_slice: accepted requests go into a scoreboard queue and are
// popped when the AR channel fires; per-scenario tasks check handshake and counter state.
module tb_ifu_axi_ar_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_id;
  logic        ifu_axi_arvalid;
  logic        ifu_axi_arready;
  logic [31:0] ifu_axi_araddr;
  logic [2:0]  ifu_axi_arid;
  logic        rsp_done;
  logic [2:0]  outstanding;
  logic        err_underflow;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  i;
  } ar_t;
  ar_t sb_q[$];

  ifu_axi_ar_slice #(.ADDR_W(32), .ID_W(3), .MAX_OUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_id          (req_id),
    .ifu_axi_arvalid (ifu_axi_arvalid),
    .ifu_axi_arready (ifu_axi_arready),
    .ifu_axi_araddr  (ifu_axi_araddr),
    .ifu_axi_arid    (ifu_axi_arid),
    .rsp_done        (rsp_done),
    .outstanding     (outstanding),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  // Monitor: reads pre-edge values at the rising edge (DUT state updates land after).
  initial begin
    ar_t         exp;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_a = '0;
    logic [2:0]  hold_i = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        sb_q.delete();
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          total++;
          if (ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== hold_a || ifu_axi_arid !== hold_i) begin
            bad++;
            $display("FAIL ar_stable: got v=%0b a=%h id=%0d need v=1 a=%h id=%0d",
                     ifu_axi_arvalid, ifu_axi_araddr, ifu_axi_arid, hold_a, hold_i);
          end
        end
        hold_pend = ifu_axi_arvalid && !ifu_axi_arready;
        hold_a    = ifu_axi_araddr;
        hold_i    = ifu_axi_arid;
        if (ifu_axi_arvalid && ifu_axi_arready) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL ar_unexpected: got a=%h id=%0d need no transfer", ifu_axi_araddr, ifu_axi_arid);
          end else begin
            exp = sb_q.pop_front();
            if (ifu_axi_araddr !== exp.a || ifu_axi_arid !== exp.i) begin
              bad++;
              $display("FAIL ar_order: got a=%h id=%0d need a=%h id=%0d",
                       ifu_axi_araddr, ifu_axi_arid, exp.a, exp.i);
            end else begin
              $display("ar  a=%h id=%0d", ifu_axi_araddr, ifu_axi_arid);
            end
          end
        end
        if (req_valid && req_ready) begin
          sb_q.push_back('{a: req_addr, i: req_id});
          $display("req a=%h id=%0d", req_addr, req_id);
        end
      end
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic [2:0] id);
    req_valid = 1'b1;
    req_addr  = a;
    req_id    = id;
  endtask

  task automatic pulse_done(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rsp_done = 1'b1;
    end
    @(negedge clk);
    rsp_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_id = '0;
    ifu_axi_arready = 1'b0; rsp_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (req_ready !== 1'b1 || ifu_axi_arvalid !== 1'b0 || ifu_axi_araddr !== 32'h0 ||
        ifu_axi_arid !== 3'd0 || outstanding !== 3'd0 || err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%0b v=%0b a=%h id=%0d out=%0d err=%0b need 1 0 0 0 0 0",
               req_ready, ifu_axi_arvalid, ifu_axi_araddr, ifu_axi_arid, outstanding, err_underflow);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    ifu_axi_arready = 1'b1;
    drive_req(32'h1000, 3'd2);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== 32'h1000 || ifu_axi_arid !== 3'd2 || outstanding !== 3'd1) begin
      bad++;
      $display("FAIL single_ar: got v=%0b a=%h id=%0d out=%0d need 1 00001000 2 1",
               ifu_axi_arvalid, ifu_axi_araddr, ifu_axi_arid, outstanding);
    end
    @(negedge clk);
    total++;
    if (ifu_axi_arvalid !== 1'b0) begin
      bad++; $display("FAIL single_drain: got v=%0b need 0", ifu_axi_arvalid);
    end
    pulse_done(1);
    total++;
    if (outstanding !== 3'd0) begin
      bad++; $display("FAIL single_done: got out=%0d need 0", outstanding);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ifu_axi_arready = 1'b0;
    drive_req(32'hA000, 3'd1);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== 32'hA000) begin
      bad++; $display("FAIL b2b_one: got rdy=%0b v=%0b a=%h need 1 1 0000a000", req_ready, ifu_axi_arvalid, ifu_axi_araddr);
    end
    drive_req(32'hB000, 3'd3);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || ifu_axi_araddr !== 32'hA000) begin
      bad++; $display("FAIL b2b_full: got rdy=%0b a=%h need 0 0000a000", req_ready, ifu_axi_araddr);
    end
    drive_req(32'hC000, 3'd5);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || ifu_axi_araddr !== 32'hA000 || outstanding !== 3'd2) begin
      bad++; $display("FAIL b2b_hold: got rdy=%0b a=%h out=%0d need 0 0000a000 2", req_ready, ifu_axi_araddr, outstanding);
    end
    ifu_axi_arready = 1'b1;
    @(negedge clk);
    total++;
    if (ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== 32'hB000 || req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_drainB: got v=%0b a=%h rdy=%0b need 1 0000b000 1", ifu_axi_arvalid, ifu_axi_araddr, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== 32'hC000 || ifu_axi_arid !== 3'd5) begin
      bad++; $display("FAIL b2b_drainC: got v=%0b a=%h id=%0d need 1 0000c000 5", ifu_axi_arvalid, ifu_axi_araddr, ifu_axi_arid);
    end
    @(negedge clk);
    total++;
    if (ifu_axi_arvalid !== 1'b0 || outstanding !== 3'd3) begin
      bad++; $display("FAIL b2b_end: got v=%0b out=%0d need 0 3", ifu_axi_arvalid, outstanding);
    end
    pulse_done(3);
  endtask

  task automatic test_max_out();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifu_axi_arready = 1'b1;
      drive_req(32'h2000 + 32'(i * 16), 3'(i));
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || outstanding !== 3'd4) begin
      bad++; $display("FAIL max_cap: got rdy=%0b out=%0d need 0 4", req_ready, outstanding);
    end
    drive_req(32'hE000, 3'd6);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || ifu_axi_arvalid !== 1'b0 || outstanding !== 3'd4) begin
      bad++; $display("FAIL max_block: got rdy=%0b v=%0b out=%0d need 0 0 4", req_ready, ifu_axi_arvalid, outstanding);
    end
    rsp_done = 1'b1;
    @(negedge clk);
    rsp_done = 1'b0;
    total++;
    if (req_ready !== 1'b1 || outstanding !== 3'd3) begin
      bad++; $display("FAIL max_release: got rdy=%0b out=%0d need 1 3", req_ready, outstanding);
    end
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (outstanding !== 3'd4 || ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== 32'hE000) begin
      bad++; $display("FAIL max_refill: got out=%0d v=%0b a=%h need 4 1 0000e000", outstanding, ifu_axi_arvalid, ifu_axi_araddr);
    end
    pulse_done(4);
    total++;
    if (outstanding !== 3'd0) begin
      bad++; $display("FAIL max_drain: got out=%0d need 0", outstanding);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    ifu_axi_arready = 1'b1;
    drive_req(32'h3000, 3'd1);
    @(negedge clk);
    drive_req(32'h3010, 3'd2);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (outstanding !== 3'd2) begin
      bad++; $display("FAIL simul_pre: got out=%0d need 2", outstanding);
    end
    @(negedge clk);
    drive_req(32'h3020, 3'd3);
    rsp_done = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_done  = 1'b0;
    total++;
    if (outstanding !== 3'd2 || ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== 32'h3020) begin
      bad++; $display("FAIL simul_same: got out=%0d v=%0b a=%h need 2 1 00003020", outstanding, ifu_axi_arvalid, ifu_axi_araddr);
    end
    pulse_done(2);
    total++;
    if (outstanding !== 3'd0) begin
      bad++; $display("FAIL simul_drain: got out=%0d need 0", outstanding);
    end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    rsp_done = 1'b1;
    @(negedge clk);
    rsp_done = 1'b0;
    total++;
    if (err_underflow !== 1'b1 || outstanding !== 3'd0) begin
      bad++; $display("FAIL uflow_set: got err=%0b out=%0d need 1 0", err_underflow, outstanding);
    end
    repeat (3) @(negedge clk);
    total++;
    if (err_underflow !== 1'b1) begin
      bad++; $display("FAIL uflow_sticky: got err=%0b need 1", err_underflow);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (err_underflow !== 1'b0) begin
      bad++; $display("FAIL uflow_clear: got err=%0b need 0", err_underflow);
    end
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    ifu_axi_arready = 1'b0;
    drive_req(32'h4000, 3'd4);
    @(negedge clk);
    drive_req(32'h4010, 3'd5);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (ifu_axi_arvalid !== 1'b1 || req_ready !== 1'b0 || ifu_axi_araddr !== 32'h4000) begin
      bad++; $display("FAIL rstfull_pre: got v=%0b rdy=%0b a=%h need 1 0 00004000", ifu_axi_arvalid, req_ready, ifu_axi_araddr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (ifu_axi_arvalid !== 1'b0 || outstanding !== 3'd0 || req_ready !== 1'b1 ||
        ifu_axi_araddr !== 32'h0 || ifu_axi_arid !== 3'd0) begin
      bad++; $display("FAIL rstfull_post: got v=%0b out=%0d rdy=%0b a=%h id=%0d need 0 0 1 0 0",
                      ifu_axi_arvalid, outstanding, req_ready, ifu_axi_araddr, ifu_axi_arid);
    end
    ifu_axi_arready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (ifu_axi_arvalid !== 1'b0) begin
      bad++; $display("FAIL rstfull_stale: got v=%0b need 0", ifu_axi_arvalid);
    end
    drive_req(32'h5000, 3'd7);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (ifu_axi_arvalid !== 1'b1 || ifu_axi_araddr !== 32'h5000 || outstanding !== 3'd1) begin
      bad++; $display("FAIL rstfull_fresh: got v=%0b a=%h out=%0d need 1 00005000 1", ifu_axi_arvalid, ifu_axi_araddr, outstanding);
    end
    pulse_done(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_max_out();
    test_simultaneous();
    test_underflow();
    test_reset_full();
    repeat (3) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_empty: got %0d pending need 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
